// File: rtl/fifo_flags.sv
// Single-clock FIFO with selectable FWFT/registered read, programmable
// almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module fifo_flags #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int FWFT     = 1,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wd,
   input  logic             pop,
   output logic [WIDTH-1:0] rd,
   output logic             rd_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;
   logic [CNT_W-1:0] next_count;

   always_comb begin
      push_ok = push & ~full;
      pop_ok  = pop & ~empty;
      case ({push_ok, pop_ok})
         2'b10:   next_count = count + 1'b1;
         2'b01:   next_count = count - 1'b1;
         default: next_count = count;
      endcase
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= wd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Flags are registered from the next count, so they never depend on push/pop combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= (AF_C == '0);
         almost_empty <= 1'b1;
      end else begin
         count        <= next_count;
         full         <= (next_count == DEPTH_C);
         empty        <= (next_count == '0);
         almost_full  <= (next_count >= AF_C);
         almost_empty <= (next_count <= AE_C);
      end
   end

   // A new error in the same cycle as clr_err wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (overflow & ~clr_err) | (push & full);
         underflow <= (underflow & ~clr_err) | (pop & empty);
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rd       = mem[rd_ptr];
         assign rd_valid = ~empty;
      end else begin : g_reg
         logic [WIDTH-1:0] rd_q;
         logic             rd_valid_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               rd_q       <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_valid_q <= pop_ok;
               if (pop_ok)
                  rd_q <= mem[rd_ptr];
            end
         end

         assign rd       = rd_q;
         assign rd_valid = rd_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench: one FWFT and one registered-read FIFO share the same stimulus;
// every comparison is an immediate assertion against hand-computed values.
module tb_fifo_flags;

   logic       clk = 1'b0;
   logic       rst;
   logic       push;
   logic [7:0] wd;
   logic       pop;
   logic       clr_err;

   logic [7:0] a_rd, b_rd;
   logic       a_rdv, b_rdv;
   logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
   logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
   logic [4:0] a_cnt, b_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fifo_flags #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) dut_a (
      .clk(clk), .rst(rst), .push(push), .wd(wd), .pop(pop),
      .rd(a_rd), .rd_valid(a_rdv), .full(a_full), .empty(a_empty),
      .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
      .overflow(a_ovf), .underflow(a_unf), .clr_err(clr_err)
   );

   fifo_flags #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) dut_b (
      .clk(clk), .rst(rst), .push(push), .wd(wd), .pop(pop),
      .rd(b_rd), .rd_valid(b_rdv), .full(b_full), .empty(b_empty),
      .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
      .overflow(b_ovf), .underflow(b_unf), .clr_err(clr_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, take the edge, sample 1 time unit later.
   task automatic cyc(input logic p, input logic [7:0] d, input logic q, input logic c);
      push = p; wd = d; pop = q; clr_err = c;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; clr_err = 1'b0;
   endtask

   task automatic chk_status(input string tag, input int c);
      chk({tag, "_cnt"},   a_cnt, c);
      chk({tag, "_cnt_b"}, b_cnt, c);
      chk({tag, "_empty"}, a_empty, (c == 0));
      chk({tag, "_full"},  a_full, (c == 16));
      chk({tag, "_af"},    a_af, (c >= 14));
      chk({tag, "_ae"},    a_ae, (c <= 2));
   endtask

   logic [7:0] exp_rd;
   logic [7:0] nxt_wd;

   initial begin
      rst = 1'b1; push = 1'b0; wd = '0; pop = 1'b0; clr_err = 1'b0;
      @(posedge clk); #1;
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;

      // Reset state
      chk_status("rst", 0);
      chk("rst_ovf", a_ovf, 0);
      chk("rst_unf", a_unf, 0);
      chk("rst_rdv_a", a_rdv, 0);
      chk("rst_rdv_b", b_rdv, 0);
      chk("rst_rd_b", b_rd, 0);

      // Fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 8'(i), 1'b0, 1'b0);
         chk_status("fill", i + 1);
         chk("fill_rdv_a", a_rdv, 1);
      end
      chk("fill_head_a", a_rd, 8'h00);

      // Push while full is dropped
      cyc(1'b1, 8'hAA, 1'b0, 1'b0);
      chk_status("ovf", 16);
      chk("ovf_flag", a_ovf, 1);
      chk("ovf_flag_b", b_ovf, 1);
      chk("ovf_unf", a_unf, 0);

      // Drain in order; 0xAA must never appear
      for (int i = 0; i < 16; i++) begin
         chk("drain_rd_a", a_rd, 8'(i));
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("drain_rd_b", b_rd, 8'(i));
         chk("drain_rdv_b", b_rdv, 1);
         chk_status("drain", 15 - i);
      end
      chk("drain_ovf_sticky", a_ovf, 1);
      chk("drain_rdv_a", a_rdv, 0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_rdv_b", b_rdv, 0);
      chk("idle_rd_b_hold", b_rd, 8'h0F);

      // Pop on empty, then clear
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("unf_set", a_unf, 1);
      chk("unf_set_b", b_unf, 1);
      chk("unf_rdv_b", b_rdv, 0);
      chk_status("unf", 0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_unf", a_unf, 0);
      chk("clr_ovf", a_ovf, 0);
      chk_status("clr", 0);

      // Wrap-around with steady occupancy of 5
      nxt_wd = 8'h20;
      exp_rd = 8'h20;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, nxt_wd, 1'b0, 1'b0);
         nxt_wd++;
      end
      chk_status("wrap_pre", 5);
      for (int i = 0; i < 40; i++) begin
         chk("wrap_rd_a", a_rd, exp_rd);
         cyc(1'b1, nxt_wd, 1'b1, 1'b0);
         chk("wrap_rd_b", b_rd, exp_rd);
         chk("wrap_cnt", a_cnt, 5);
         nxt_wd++;
         exp_rd++;
      end
      chk("wrap_ovf", a_ovf, 0);
      chk("wrap_unf", a_unf, 0);
      for (int i = 0; i < 5; i++) begin
         chk("wrap_tail_a", a_rd, exp_rd);
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         chk("wrap_tail_b", b_rd, exp_rd);
         exp_rd++;
      end
      chk_status("wrap_end", 0);

      // Simultaneous push/pop on empty
      cyc(1'b1, 8'h3C, 1'b1, 1'b0);
      chk_status("pp_empty", 1);
      chk("pp_unf", a_unf, 1);
      chk("pp_ovf", a_ovf, 0);
      chk("pp_rd_a", a_rd, 8'h3C);
      chk("pp_rdv_a", a_rdv, 1);
      chk("pp_rdv_b", b_rdv, 0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pp_rd_b", b_rd, 8'h3C);
      chk("pp_rdv_b_pulse", b_rdv, 1);
      chk_status("pp_pop", 0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      chk("pp_rdv_b_end", b_rdv, 0);
      chk("pp_rd_b_hold", b_rd, 8'h3C);

      // clr_err coinciding with a new underflow: the new error wins
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      chk("clr_vs_new", a_unf, 1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_final", a_unf, 0);

      // Reset mid-operation with count = 9 and an error pending
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++)
         cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      chk_status("pre_rst", 9);
      chk("pre_rst_unf", a_unf, 1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_rd_b", b_rd, 8'h70);
      rst = 1'b1;
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      chk_status("mid_rst", 0);
      chk("mid_rst_unf", a_unf, 0);
      chk("mid_rst_ovf", a_ovf, 0);
      chk("mid_rst_rd_b", b_rd, 0);
      chk("mid_rst_rdv_b", b_rdv, 0);
      chk("mid_rst_rdv_a", a_rdv, 0);

      cyc(1'b1, 8'h55, 1'b0, 1'b0);
      chk_status("post_push", 1);
      chk("post_rd_a", a_rd, 8'h55);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post_rd_b", b_rd, 8'h55);
      chk("post_rdv_b", b_rdv, 1);
      chk_status("post_pop", 0);
      chk("post_unf", a_unf, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
